load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one request from execute onto a single-beat word bus.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats instead of flagging them.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [1:0]  lwhb,
  input  logic        lunsigned,
  input  logic [1:0]  swhb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  // Bus handshake: mem_req with mem_addr/mem_be/mem_we/mem_wdata stays stable
  // until a rising edge samples mem_ack=1; that edge completes the beat.
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_nxt;

  logic        req_store, req_load;
  logic [2:0]  req_size;
  logic        req_misal;
  logic        go_bus, go_split, go_misal;

  logic        store_r, load_r, uns_r, cross_r, misal_r;
  logic [2:0]  size_r;
  logic [1:0]  off_r;
  logic [29:0] word_r;
  logic [31:0] wdata_r, lo_r;

  logic [3:0]  size_mask;
  logic [7:0]  be_span;
  logic [63:0] wd_span, rd_span;
  logic [31:0] rd_word, ld_value;
  logic        last_ack;

  always_comb begin
    req_store = memwrite;
    req_load  = !memwrite && memtoreg;
    req_size  = 3'd0;
    if (req_store) begin
      case (swhb)
        2'b01:   req_size = 3'd4;
        2'b10:   req_size = 3'd2;
        2'b11:   req_size = 3'd1;
        default: req_size = 3'd0;
      endcase
    end else if (req_load) begin
      case (lwhb)
        2'b01:   req_size = 3'd2;
        2'b10:   req_size = 3'd1;
        default: req_size = 3'd4;
      endcase
    end
    req_misal = (req_size == 3'd2 && addr[0]) || (req_size == 3'd4 && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
    go_bus   = req_size != 3'd0;
    go_split = go_bus && (({1'b0, req_size} + {2'b00, addr[1:0]}) > 4'd4);
    go_misal = 1'b0;
`else
    go_bus   = req_size != 3'd0 && !req_misal;
    go_split = 1'b0;
    go_misal = req_size != 3'd0 && req_misal;
`endif
  end

  // Lanes are laid out over two consecutive words; the upper half only matters when split.
  always_comb begin
    case (size_r)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be_span  = {4'b0000, size_mask} << off_r;
    wd_span  = {32'd0, wdata_r} << {off_r, 3'b000};
    rd_span  = (state == BEAT2) ? {mem_rdata, lo_r} : {32'd0, mem_rdata};
    rd_word  = 32'(rd_span >> {off_r, 3'b000});
    case (size_r)
      3'd1:    ld_value = {{24{!uns_r && rd_word[7]}}, rd_word[7:0]};
      3'd2:    ld_value = {{16{!uns_r && rd_word[15]}}, rd_word[15:0]};
      default: ld_value = rd_word;
    endcase
    last_ack = mem_ack && ((state == BEAT1 && !cross_r) || state == BEAT2);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = go_bus ? BEAT1 : RESP;
      BEAT1:   if (mem_ack) state_nxt = cross_r ? BEAT2 : RESP;
      BEAT2:   if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = state != IDLE;
    done      = state == RESP;
    misalign  = misal_r && state == RESP;
    mem_req   = state == BEAT1 || state == BEAT2;
    mem_we    = mem_req && store_r;
    mem_addr  = 32'd0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (state == BEAT1) begin
      mem_addr = {word_r, 2'b00};
      mem_be   = be_span[3:0];
      if (store_r) mem_wdata = wd_span[31:0];
    end else if (state == BEAT2) begin
      mem_addr = {word_r + 30'd1, 2'b00};
      mem_be   = be_span[7:4];
      if (store_r) mem_wdata = wd_span[63:32];
    end
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_r <= 1'b0;
      load_r  <= 1'b0;
      uns_r   <= 1'b0;
      cross_r <= 1'b0;
      misal_r <= 1'b0;
      size_r  <= 3'd0;
      off_r   <= 2'b00;
      word_r  <= 30'd0;
      wdata_r <= 32'd0;
      lo_r    <= 32'd0;
      rdata   <= 32'd0;
    end else begin
      if (state == IDLE && start) begin
        store_r <= req_store;
        load_r  <= req_load;
        uns_r   <= lunsigned;
        cross_r <= go_split;
        misal_r <= go_misal;
        size_r  <= req_size;
        off_r   <= addr[1:0];
        word_r  <= addr[31:2];
        wdata_r <= wdata;
      end
      if (state == BEAT1 && mem_ack) lo_r <= mem_rdata;
      if (last_ack && load_r) rdata <= ld_value;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table of single requests plus sequences for
// word-crossing accesses, mid-beat reset and start-while-busy.
module tb_load_store_unit;
  logic        clk, reset, start, memwrite, memtoreg, lunsigned, mem_ack;
  logic [1:0]  lwhb, swhb, dbg_state;
  logic [31:0] addr, wdata, mem_rdata, rdata, mem_addr, mem_wdata;
  logic        busy, done, misalign, mem_req, mem_we;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        mw, mr;
    logic [1:0]  lwhb;
    logic        lu;
    logic [1:0]  swhb;
    logic [31:0] addr, wdata, rd;
    int          dly;
    logic        bus;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic        ewe;
    logic [31:0] ewdata, erdata;
    logic        emis;
  } vec_t;
  vec_t vecs[$];

  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .memtoreg(memtoreg),
    .lwhb(lwhb), .lunsigned(lunsigned), .swhb(swhb), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mw, input logic mr, input logic [1:0] lw,
                              input logic lu, input logic [1:0] sw, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int dly,
                              input logic bus, input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic ewe, input logic [31:0] ewd, input logic [31:0] erd,
                              input logic emis);
    vec_t v;
    v.mw = mw; v.mr = mr; v.lwhb = lw; v.lu = lu; v.swhb = sw;
    v.addr = a; v.wdata = wd; v.rd = rd; v.dly = dly;
    v.bus = bus; v.eaddr = eaddr; v.ebe = ebe; v.ewe = ewe;
    v.ewdata = ewd; v.erdata = erd; v.emis = emis;
    return v;
  endfunction

  // driver tasks (called at a negedge, return at a negedge)
  task automatic idle_inputs();
    start = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; lwhb = 2'b00; lunsigned = 1'b0;
    swhb = 2'b00; addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
  endtask

  task automatic drive_req(input logic mw, input logic mr, input logic [1:0] lw, input logic lu,
                           input logic [1:0] sw, input logic [31:0] a, input logic [31:0] wd);
    memwrite = mw; memtoreg = mr; lwhb = lw; lunsigned = lu; swhb = sw; addr = a; wdata = wd;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ack_beat(input logic [31:0] rd);
    mem_rdata = rd; mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic finish_resp(input logic [31:0] erd, input logic emis);
    logic [31:0] exp_rd;
    check("done", done, 1);
    check("misalign", misalign, emis);
    exp_rd = exp_q.pop_front();
    check("rdata", rdata, exp_rd);
    @(posedge clk); @(negedge clk);
    check("done_drop", done, 0);
    check("busy_drop", busy, 0);
  endtask

  task automatic apply(input vec_t v);
    exp_q.push_back(v.erdata);
    drive_req(v.mw, v.mr, v.lwhb, v.lu, v.swhb, v.addr, v.wdata);
    if (v.bus) begin
      check("mem_req", mem_req, 1);
      check("mem_addr", mem_addr, v.eaddr);
      check("mem_be", {28'd0, mem_be}, {28'd0, v.ebe});
      check("mem_we", mem_we, v.ewe);
      if (v.ewe) check("mem_wdata", mem_wdata, v.ewdata);
      for (int i = 0; i < v.dly; i++) begin
        @(posedge clk); @(negedge clk);
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, v.eaddr);
        check("hold_be", {28'd0, mem_be}, {28'd0, v.ebe});
      end
      ack_beat(v.rd);
    end else begin
      check("no_mem_req", mem_req, 0);
    end
    finish_resp(v.erdata, v.emis);
  endtask

  initial begin
    int done_cnt;
    int req_cnt;
    idle_inputs();
    reset = 1'b0;

    // lw at 0x100 acked in the first request cycle: done lands in the third cycle counting the start cycle.
    vecs.push_back(mk(0,1,2'b00,0,2'b00,32'h100,32'h0,32'hDEADBEEF,0, 1,32'h100,4'b1111,0,32'h0,32'hDEADBEEF,0));
    vecs.push_back(mk(0,1,2'b10,0,2'b00,32'h103,32'h0,32'h80FFFFFF,1, 1,32'h100,4'b1000,0,32'h0,32'hFFFFFF80,0));
    vecs.push_back(mk(0,1,2'b10,1,2'b00,32'h103,32'h0,32'h80FFFFFF,0, 1,32'h100,4'b1000,0,32'h0,32'h00000080,0));
    vecs.push_back(mk(1,0,2'b00,0,2'b10,32'h22,32'h0000ABCD,32'h0,2, 1,32'h20,4'b1100,1,32'hABCD0000,32'h00000080,0));
    vecs.push_back(mk(0,1,2'b01,0,2'b00,32'h42,32'h0,32'h92345678,0, 1,32'h40,4'b1100,0,32'h0,32'hFFFF9234,0));
    vecs.push_back(mk(0,1,2'b01,1,2'b00,32'h40,32'h0,32'h12348765,1, 1,32'h40,4'b0011,0,32'h0,32'h00008765,0));
    vecs.push_back(mk(0,1,2'b11,1,2'b00,32'h8,32'h0,32'h80000001,0, 1,32'h8,4'b1111,0,32'h0,32'h80000001,0));
    vecs.push_back(mk(1,0,2'b00,0,2'b11,32'h11,32'h000000A5,32'h0,0, 1,32'h10,4'b0010,1,32'h0000A500,32'h80000001,0));
    vecs.push_back(mk(1,1,2'b00,0,2'b01,32'h200,32'hCAFEF00D,32'h0,0, 1,32'h200,4'b1111,1,32'hCAFEF00D,32'h80000001,0));
    vecs.push_back(mk(0,0,2'b00,0,2'b01,32'h300,32'h12345678,32'h0,0, 0,32'h0,4'b0000,0,32'h0,32'h80000001,0));
    vecs.push_back(mk(1,0,2'b00,0,2'b00,32'h300,32'h12345678,32'h0,0, 0,32'h0,4'b0000,0,32'h0,32'h80000001,0));
    vecs.push_back(mk(0,1,2'b10,0,2'b00,32'h101,32'h0,32'h00007F00,0, 1,32'h100,4'b0010,0,32'h0,32'h0000007F,0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(0,1,2'b01,0,2'b00,32'h41,32'h0,32'h00ABCD00,0, 1,32'h40,4'b0110,0,32'h0,32'hFFFFABCD,0));
`else
    vecs.push_back(mk(0,1,2'b01,0,2'b00,32'h41,32'h0,32'h00ABCD00,0, 0,32'h0,4'b0000,0,32'h0,32'h0000007F,1));
`endif
    vecs.push_back(mk(0,1,2'b10,0,2'b00,32'h102,32'h0,32'h00800000,0, 1,32'h100,4'b0100,0,32'h0,32'hFFFFFF80,0));

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_misalign", misalign, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // word-crossing store and load at 0x43
`ifdef LSU_MISALIGN_SPLIT_EN
    exp_q.push_back(32'hFFFFFF80);
    drive_req(1, 0, 2'b00, 0, 2'b01, 32'h43, 32'h11223344);
    check("sp_st1_addr", mem_addr, 32'h40);
    check("sp_st1_be", {28'd0, mem_be}, 32'h8);
    check("sp_st1_we", mem_we, 1);
    check("sp_st1_lane3", {24'd0, mem_wdata[31:24]}, 32'h44);
    ack_beat(32'h0);
    check("sp_st2_req", mem_req, 1);
    check("sp_st2_addr", mem_addr, 32'h44);
    check("sp_st2_be", {28'd0, mem_be}, 32'h7);
    check("sp_st2_lanes", {8'd0, mem_wdata[23:0]}, 32'h112233);
    ack_beat(32'h0);
    finish_resp(32'hFFFFFF80, 0);

    exp_q.push_back(32'h223344AA);
    drive_req(0, 1, 2'b00, 0, 2'b00, 32'h43, 32'h0);
    check("sp_ld1_addr", mem_addr, 32'h40);
    check("sp_ld1_be", {28'd0, mem_be}, 32'h8);
    ack_beat(32'hAABBCCDD);
    check("sp_ld2_addr", mem_addr, 32'h44);
    check("sp_ld2_be", {28'd0, mem_be}, 32'h7);
    check("sp_ld2_done", done, 0);
    ack_beat(32'h11223344);
    finish_resp(32'h223344AA, 0);
`else
    apply(mk(1,0,2'b00,0,2'b01,32'h43,32'h11223344,32'h0,0, 0,32'h0,4'b0000,0,32'h0,32'hFFFFFF80,1));
    apply(mk(0,1,2'b00,0,2'b00,32'h43,32'h0,32'hAABBCCDD,0, 0,32'h0,4'b0000,0,32'h0,32'hFFFFFF80,1));
`endif

    // reset mid-beat: outputs clear between clock edges, then a fresh request works
    drive_req(0, 1, 2'b00, 0, 2'b00, 32'h500, 32'h0);
    check("abort_req_before", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_be", {28'd0, mem_be}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apply(mk(0,1,2'b00,0,2'b00,32'h600,32'h0,32'h0BADF00D,0, 1,32'h600,4'b1111,0,32'h0,32'h0BADF00D,0));

    // start pulsed while a beat waits five cycles for ack
    done_cnt = 0;
    req_cnt  = 0;
    exp_q.push_back(32'h13572468);
    drive_req(0, 1, 2'b00, 0, 2'b00, 32'h300, 32'h0);
    memwrite = 1'b1; swhb = 2'b01; addr = 32'h400; wdata = 32'hFFFFFFFF; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("busy_hold_addr", mem_addr, 32'h300);
      check("busy_hold_we", mem_we, 0);
      if (done) done_cnt++;
    end
    ack_beat(32'h13572468);
    check("busy_rdata", rdata, exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      if (done) done_cnt++;
      if (mem_req) req_cnt++;
      @(posedge clk); @(negedge clk);
    end
    check("busy_done_count", done_cnt, 1);
    check("busy_no_second_req", req_cnt, 0);
    check("busy_final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
